frog_controller: RTL

Game-logic stage directly downstream of the per-lane car movers. Consumes debounced button pulses and every car's 5-bit X position, moves the frog on the 20x15 grid, and detects car collisions and goal arrival. Tracks lives and score. Publishes frog position and game status to the renderer and the score display.

---
 rtl/frog_controller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/frog_controller.sv
// rtl/frog_controller.sv - frog movement, car collision, goal, lives and score control
//
// Purpose: moves the frog on the 20x15 grid from debounced button pulses,
// detects collisions against every lane's car X, detects goal arrival, and
// tracks lives/score through the PLAY/DEAD/WIN/GAMEOVER states.
// Optional build macro: FROG_BLINK_EN (blink the frog sprite while DEAD).
//
// Ports:
//   i_Clk          system clock (25 MHz pixel clock domain)
//   i_Reset        synchronous active-high reset
//   i_up/i_down    single-cycle move pulses (y-1 / y+1)
//   i_left/i_right single-cycle move pulses (x-1 / x+1)
//   i_car_x        packed car X per lane, lane k = bits [5k+4:5k]
//   o_frog_x/y     frog column 0..19 / row 0..14
//   o_lives        remaining lives
//   o_score        goals reached, saturating at 99
//   o_hit/o_win    one-cycle pulses on collision / goal
//   o_game_over    high while in GAMEOVER
//   o_frog_visible renderer enable for the frog sprite

module frog_controller #(
    parameter int          NUM_LANES      = 4,
    parameter int          FIRST_LANE_ROW = 10,
    parameter int          FROG_START_X   = 9,
    parameter int          FROG_START_Y   = 14,
    parameter int          LIVES_INIT     = 3,
    parameter logic [23:0] DEATH_TICKS    = 24'd12_500_000,
    parameter logic [23:0] WIN_TICKS      = 24'd12_500_000
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_up,
    input  logic                   i_down,
    input  logic                   i_left,
    input  logic                   i_right,
    input  logic [5*NUM_LANES-1:0] i_car_x,
    output logic [4:0]             o_frog_x,
    output logic [3:0]             o_frog_y,
    output logic [1:0]             o_lives,
    output logic [6:0]             o_score,
    output logic                   o_hit,
    output logic                   o_win,
    output logic                   o_game_over,
    output logic                   o_frog_visible
);

    localparam logic [4:0] START_X   = 5'(FROG_START_X);
    localparam logic [3:0] START_Y   = 4'(FROG_START_Y);
    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);
    localparam logic [4:0] MAX_X     = 5'd19;
    localparam logic [3:0] MAX_Y     = 4'd14;

    typedef enum logic [1:0] {S_PLAY, S_DEAD, S_WIN, S_GAMEOVER} state_t;

    state_t      r_state;
    logic [4:0]  r_frog_x;
    logic [3:0]  r_frog_y;
    logic [1:0]  r_lives;
    logic [6:0]  r_score;
    logic [23:0] r_hold;
    logic        r_hit;
    logic        r_win;
    logic        r_game_over;
    logic        w_hit;
    logic        w_any_btn;

    // Frog column never exceeds 19, so out-of-range car X can never match.
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (int'(r_frog_y) == FIRST_LANE_ROW + k && r_frog_x == i_car_x[5*k +: 5])
                w_hit = 1'b1;
        end
    end

    assign w_any_btn = i_up | i_down | i_left | i_right;

`ifdef FROG_BLINK_EN
    logic r_visible;
    assign o_frog_visible = r_visible;
`else
    assign o_frog_visible = 1'b1;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= S_PLAY;
            r_frog_x    <= START_X;
            r_frog_y    <= START_Y;
            r_lives     <= LIVES_RST;
            r_score     <= 7'd0;
            r_hold      <= 24'd0;
            r_hit       <= 1'b0;
            r_win       <= 1'b0;
            r_game_over <= 1'b0;
`ifdef FROG_BLINK_EN
            r_visible   <= 1'b1;
`endif
        end else begin
            r_hit <= 1'b0;
            r_win <= 1'b0;
            case (r_state)
                S_PLAY: begin
                    // Collision beats goal, goal beats any button move.
                    if (w_hit) begin
                        r_state <= S_DEAD;
                        r_lives <= (r_lives != 2'd0) ? r_lives - 2'd1 : 2'd0;
                        r_hit   <= 1'b1;
                        r_hold  <= DEATH_TICKS - 24'd1;
                    end else if (r_frog_y == 4'd0) begin
                        r_state <= S_WIN;
                        r_score <= (r_score < 7'd99) ? r_score + 7'd1 : 7'd99;
                        r_win   <= 1'b1;
                        r_hold  <= WIN_TICKS - 24'd1;
                    end else if (i_up) begin
                        if (r_frog_y != 4'd0) r_frog_y <= r_frog_y - 4'd1;
                    end else if (i_down) begin
                        if (r_frog_y != MAX_Y) r_frog_y <= r_frog_y + 4'd1;
                    end else if (i_left) begin
                        if (r_frog_x != 5'd0) r_frog_x <= r_frog_x - 5'd1;
                    end else if (i_right) begin
                        if (r_frog_x != MAX_X) r_frog_x <= r_frog_x + 5'd1;
                    end
                end
                S_DEAD, S_WIN: begin
`ifdef FROG_BLINK_EN
                    if (r_state == S_DEAD && r_hold[21:0] == 22'd0)
                        r_visible <= ~r_visible;
`endif
                    if (r_hold == 24'd0) begin
                        if (r_state == S_DEAD && r_lives == 2'd0) begin
                            r_state     <= S_GAMEOVER;
                            r_game_over <= 1'b1;
                        end else begin
                            r_state  <= S_PLAY;
                            r_frog_x <= START_X;
                            r_frog_y <= START_Y;
                        end
`ifdef FROG_BLINK_EN
                        r_visible <= 1'b1;
`endif
                    end else begin
                        r_hold <= r_hold - 24'd1;
                    end
                end
                S_GAMEOVER: begin
                    // A button only restarts the game; it does not move the frog.
                    if (w_any_btn) begin
                        r_state     <= S_PLAY;
                        r_lives     <= LIVES_RST;
                        r_score     <= 7'd0;
                        r_frog_x    <= START_X;
                        r_frog_y    <= START_Y;
                        r_game_over <= 1'b0;
                    end
                end
                default: r_state <= S_PLAY;
            endcase
        end
    end

    assign o_frog_x    = r_frog_x;
    assign o_frog_y    = r_frog_y;
    assign o_lives     = r_lives;
    assign o_score     = r_score;
    assign o_hit       = r_hit;
    assign o_win       = r_win;
    assign o_game_over = r_game_over;

endmodule
